// File: rtl/adder_arbiter.sv
// Round-robin sequencer sharing one external combinational adder among NREQ
// requesters; returns a registered sum, a reconstructed carry and the owner index.
module adder_arbiter #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_in,
   input  logic [NREQ*WIDTH-1:0] b_in,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      add_a,
   output logic [WIDTH-1:0]      add_b,
   input  logic [WIDTH-1:0]      add_sum,
   output logic [WIDTH-1:0]      sum_out,
   output logic                  carry_out,
   output logic                  valid,
   output logic [IDW-1:0]        id_out
);
   localparam int PW = IDW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [IDW-1:0]   ptr_r;
   logic [IDW-1:0]   owner_r;
   logic [IDW-1:0]   win_s;
   logic [IDW-1:0]   ptr_nxt_s;
   logic [PW-1:0]    pick_s;
   logic             found_s;
   logic             grant_s;
   logic             capture_s;
   logic [WIDTH-1:0] a_sel_s;
   logic [WIDTH-1:0] b_sel_s;

   // Returns {found, index}: first set request at or after p, wrapping modulo NREQ.
   function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
      logic [PW-1:0]   res;
      logic [PW-1:0]   raw;
      logic [PW-1:0]   idx;
      logic [NREQ-1:0] sh;
      res = {PW{1'b0}};
      for (int i = NREQ - 1; i >= 0; i--) begin
         raw = {1'b0, p} + PW'(i);
         idx = (raw >= PW'(NREQ)) ? (raw - PW'(NREQ)) : raw;
         sh  = r >> idx;
         res = sh[0] ? {1'b1, idx[IDW-1:0]} : res;
      end
      return res;
   endfunction

   function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] k);
      logic [PW-1:0] inc;
      inc = {1'b0, k} + PW'(1);
      return (inc >= PW'(NREQ)) ? {IDW{1'b0}} : inc[IDW-1:0];
   endfunction

   assign pick_s    = rr_pick(req, ptr_r);
   assign found_s   = pick_s[IDW];
   assign win_s     = pick_s[IDW-1:0];
   assign ptr_nxt_s = rr_next(win_s);

   // Operand selection for the arbitration winner (AND-OR mux).
   always_comb begin
      a_sel_s = {WIDTH{1'b0}};
      b_sel_s = {WIDTH{1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         a_sel_s = a_sel_s | (a_in[k*WIDTH +: WIDTH] & {WIDTH{win_s == IDW'(k)}});
         b_sel_s = b_sel_s | (b_in[k*WIDTH +: WIDTH] & {WIDTH{win_s == IDW'(k)}});
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; DONE re-arbitrates without passing through IDLE.
   always_comb begin
      state_nxt_s = IDLE;
      case (state_r)
         IDLE:    state_nxt_s = found_s ? ADD : IDLE;
         ADD:     state_nxt_s = DONE;
         DONE:    state_nxt_s = found_s ? ADD : IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM output decode: when to grant and when to capture the adder result.
   always_comb begin
      grant_s   = 1'b0;
      capture_s = 1'b0;
      case (state_r)
         IDLE:    grant_s   = found_s;
         ADD:     capture_s = 1'b1;
         DONE:    grant_s   = found_s;
         default: begin
            grant_s   = 1'b0;
            capture_s = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r     <= {IDW{1'b0}};
         owner_r   <= {IDW{1'b0}};
         gnt       <= {NREQ{1'b0}};
         valid     <= 1'b0;
         add_a     <= {WIDTH{1'b0}};
         add_b     <= {WIDTH{1'b0}};
         sum_out   <= {WIDTH{1'b0}};
         carry_out <= 1'b0;
         id_out    <= {IDW{1'b0}};
      end else begin
         gnt   <= grant_s ? (NREQ'(1) << win_s) : {NREQ{1'b0}};
         valid <= capture_s;
         if (grant_s) begin
            add_a   <= a_sel_s;
            add_b   <= b_sel_s;
            owner_r <= win_s;
            ptr_r   <= ptr_nxt_s;
         end
         if (capture_s) begin
            sum_out   <= add_sum;
            // Modulo sum wrapped past A exactly when the true sum overflowed.
            carry_out <= (add_sum < add_a);
            id_out    <= owner_r;
         end
      end
   end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table for single transactions plus
// hand-written round-robin, reset and exhaustive operand sequences.
module tb_adder_arbiter;
   localparam int WIDTH = 4;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic [3:0]  gnt;
   logic [3:0]  add_a;
   logic [3:0]  add_b;
   logic [3:0]  add_sum;
   logic [3:0]  sum_out;
   logic        carry_out;
   logic        valid;
   logic [1:0]  id_out;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // The shared adder: modulo 2^WIDTH, no carry.
   assign add_sum = add_a + add_b;

   adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .sum_out(sum_out), .carry_out(carry_out), .valid(valid), .id_out(id_out)
   );

   typedef struct {
      logic [3:0] req;
      int         lane;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] exp_sum;
      logic       exp_carry;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_one(input vec_t v);
      logic [15:0] a_full;
      logic [15:0] b_full;
      a_full = (16'h5A3C & ~(16'hF << (v.lane * 4))) | (16'(v.a) << (v.lane * 4));
      b_full = (16'hC3A5 & ~(16'hF << (v.lane * 4))) | (16'(v.b) << (v.lane * 4));
      req  = v.req;
      a_in = a_full;
      b_in = b_full;
      tick();
      check("vec_gnt", 32'(gnt), 32'(v.req));
      check("vec_valid_at_gnt", 32'(valid), 32'(0));
      req  = 4'b0000;
      a_in = ~a_full;
      b_in = ~b_full;
      tick();
      check("vec_valid", 32'(valid), 32'(1));
      check("vec_gnt_clear", 32'(gnt), 32'(0));
      check("vec_sum", 32'(sum_out), 32'(v.exp_sum));
      check("vec_carry", 32'(carry_out), 32'(v.exp_carry));
      check("vec_id", 32'(id_out), 32'(v.lane));
      tick();
      check("vec_valid_drop", 32'(valid), 32'(0));
      check("vec_sum_hold", 32'(sum_out), 32'(v.exp_sum));
      a_in = 16'h0000;
      b_in = 16'h0000;
   endtask

   // Holds rq for n grants; order lists expected winners one nibble per grant.
   task automatic run_seq(input logic [3:0] rq, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] order, input int n);
      int         k;
      logic [3:0] la;
      logic [3:0] lb;
      logic [4:0] model;
      req  = rq;
      a_in = a;
      b_in = b;
      for (int i = 0; i < n; i++) begin
         k     = int'(order[i*4 +: 4]);
         la    = 4'(a >> (k * 4));
         lb    = 4'(b >> (k * 4));
         model = 5'(la) + 5'(lb);
         tick();
         check("seq_gnt", 32'(gnt), 32'(4'b0001 << k));
         check("seq_valid_at_gnt", 32'(valid), 32'(0));
         tick();
         check("seq_valid", 32'(valid), 32'(1));
         check("seq_id", 32'(id_out), 32'(k));
         check("seq_result", 32'({carry_out, sum_out}), 32'(model));
      end
      req = 4'b0000;
      tick();
      check("seq_end_idle", 32'({gnt, valid}), 32'(0));
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0] = '{req: 4'b0001, lane: 0, a: 4'h3, b: 4'h4, exp_sum: 4'h7, exp_carry: 1'b0};
      vecs[1] = '{req: 4'b0100, lane: 2, a: 4'hF, b: 4'h1, exp_sum: 4'h0, exp_carry: 1'b1};
      vecs[2] = '{req: 4'b0100, lane: 2, a: 4'h9, b: 4'h9, exp_sum: 4'h2, exp_carry: 1'b1};
      vecs[3] = '{req: 4'b1000, lane: 3, a: 4'h8, b: 4'h7, exp_sum: 4'hF, exp_carry: 1'b0};
      vecs[4] = '{req: 4'b0010, lane: 1, a: 4'hA, b: 4'h6, exp_sum: 4'h0, exp_carry: 1'b1};
      vecs[5] = '{req: 4'b0001, lane: 0, a: 4'hF, b: 4'hF, exp_sum: 4'hE, exp_carry: 1'b1};
      vecs[6] = '{req: 4'b0010, lane: 1, a: 4'h0, b: 4'h0, exp_sum: 4'h0, exp_carry: 1'b0};

      // Reset held with random requests, then release into a quiet idle.
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req  = 4'($urandom);
         a_in = 16'($urandom);
         b_in = 16'($urandom);
         tick();
      end
      check("rst_gnt", 32'(gnt), 32'(0));
      check("rst_valid", 32'(valid), 32'(0));
      check("rst_add_a", 32'(add_a), 32'(0));
      check("rst_add_b", 32'(add_b), 32'(0));
      check("rst_sum", 32'(sum_out), 32'(0));
      check("rst_carry", 32'(carry_out), 32'(0));
      check("rst_id", 32'(id_out), 32'(0));
      req   = 4'b0000;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("idle_quiet", 32'({gnt, valid}), 32'(0));
      end

      for (int i = 0; i < 7; i++) begin
         apply_one(vecs[i]);
      end

      // Fairness: all four requesting, lane k has a=k+1, b=k+5.
      pulse_reset();
      run_seq(4'b1111, 16'h4321, 16'h8765, 32'h0003_210, 5);

      // Wrap and skip: grant 2 moves ptr to 3, then 1011 gives 3,0,1.
      pulse_reset();
      run_seq(4'b0100, 16'hF9E1, 16'h2781, 32'h2, 1);
      run_seq(4'b1011, 16'hF9E1, 16'h2781, 32'h103, 3);

      // Asynchronous reset while the FSM sits in ADD.
      req  = 4'b0100;
      a_in = 16'h0700;
      b_in = 16'h0600;
      tick();
      check("midop_gnt", 32'(gnt), 32'(4'b0100));
      req = 4'b0000;
      #2;
      rst_n = 1'b0;
      #1;
      check("midop_async_clear", 32'({gnt, valid, add_a, add_b, sum_out, carry_out, id_out}), 32'(0));
      tick();
      check("midop_no_valid", 32'(valid), 32'(0));
      tick();
      check("midop_no_valid2", 32'(valid), 32'(0));
      rst_n = 1'b1;
      run_seq(4'b0110, 16'h0000, 16'h0000, 32'h21, 2);

      // Exhaustive operand sweep through requester 0.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            req  = 4'b0001;
            a_in = 16'hABC0 | 16'(a);
            b_in = 16'h5DE0 | 16'(b);
            tick();
            req = 4'b0000;
            tick();
            check("sweep_valid", 32'(valid), 32'(1));
            check("sweep_result", 32'({carry_out, sum_out}), 32'(a + b));
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares the single combinational `top` adder (A, B → Sum, WIDTH bits, modulo 2^WIDTH, no carry output) between NREQ requesters. Each requester presents an operand pair with a request. The block grants one requester at a time, drives the shared adder, registers the result with a reconstructed carry flag, and returns it tagged with the requester index. It sits between the requesting blocks and the single adder instance, which it instantiates or connects to through the `add_*` ports.

## Interface
- WIDTH, 4, operand/sum width; matches the adder.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, index width; must be ≥ clog2(NREQ).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester request level.
- a_in  in  NREQ*WIDTH  operand A; requester k on bits [k*WIDTH +: WIDTH].
- b_in  in  NREQ*WIDTH  operand B; same packing as a_in.
- gnt  out  NREQ  one-hot acknowledge pulse.
- add_a  out  WIDTH  registered operand to adder A.
- add_b  out  WIDTH  registered operand to adder B.
- add_sum  in  WIDTH  adder Sum, combinational from add_a/add_b.
- sum_out  out  WIDTH  registered result.
- carry_out  out  1  registered carry: 1 when the true sum ≥ 2^WIDTH.
- valid  out  1  one-cycle pulse; sum_out/carry_out/id_out are valid.
- id_out  out  IDW  index of the requester owning the result.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: if any req bit is set, pick winner k, latch a_in[k]/b_in[k] into add_a/add_b, set gnt[k]=1 for the next cycle, and go to ADD. Otherwise stay in IDLE.
- ADD: the adder settles. Capture sum_out ← add_sum and carry_out ← (add_sum < add_a), set id_out ← k and valid=1 for the next cycle, then go to DONE.
- DONE: valid is high this cycle. If any req is set, arbitrate exactly as in IDLE and go to ADD. Otherwise go to IDLE.
- Arbitration is round-robin. The search starts at index ptr and wraps modulo NREQ. The first set req bit wins, then ptr ← k+1 mod NREQ. ptr resets to 0.
- Handshake:
  - A requester holds req and its operands stable until it sees its gnt bit high.
  - It may drop req or change operands in the cycle after gnt.
  - If req is still high in DONE, it is treated as a new request.
- Operands are sampled only at the grant decision. Changes after that are ignored.
- Arithmetic: the sum is modulo 2^WIDTH. Carry is reconstructed; for example, 0xF+0x1 gives sum 0x0, carry 1.
- Req bits at index ≥ NREQ do not exist. A single active requester is granted every 2 cycles, since DONE re-arbitrates.

## Timing
- Reset values (asynchronous, while rst_n=0): state=IDLE, ptr=0, gnt=0, valid=0, add_a=0, add_b=0, sum_out=0, carry_out=0, id_out=0.
- Latency: req sampled high in IDLE at edge N → gnt pulse and add_a/add_b valid during cycle N+1 → valid pulse during cycle N+2.
- Outputs from a rising edge:
  - gnt is high exactly one cycle per grant and is one-hot.
  - valid is high exactly one cycle per result.
- sum_out, carry_out and id_out hold their last values while valid=0.
- Throughput: at most one result every 2 cycles under continuous requests.
- Reset asserted mid-operation: the in-flight result is discarded, no valid is emitted, and ptr returns to 0.
- Simultaneous requests: exactly one winner per decision, chosen by ptr order. The others wait with no loss.
- If req drops in the same cycle the FSM decides, the sampled value decides. A grant given against a stale req is still completed.

## Test plan
- Reset: hold rst_n=0 with random req → all outputs 0. Release with req=0 → state stays IDLE and gnt/valid stay 0 indefinitely.
- Single request: req=0001, a0=3, b0=4 → gnt=0001 one cycle later, then valid with sum_out=7, carry_out=0, id_out=0 one cycle after that.
- Overflow: requester 2 with a=0xF, b=0x1 → sum_out=0x0, carry_out=1, id_out=2. Also a=0x9, b=0x9 → sum_out=0x2, carry_out=1.
- Round-robin fairness: req=1111 held continuously with distinct operands → grant order 0,1,2,3,0. One valid every 2 cycles, and each id_out matches its expected sum.
- Pointer wrap and skip: grant 2, then req=1011 → next grant 3, then 0, then 1 (index 2 not requested).
- Async reset mid-op: assert rst_n=0 during ADD → no valid pulse. After release, req=0110 → first grant goes to 1 (ptr=0).
- Exhaustive: sweep all 256 (A,B) pairs through requester 0 and compare {carry_out,sum_out} = A+B.
